mem_port_arbiter: RTL and testbench

//  Shares the single memory port between instruction fetch (I) and load/store (D) requesters.

---
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch requester, load/store requester and unified memory
//   port signals that meet at the memory port arbiter.
//   master : arbiter view (takes requests and mem_ready/mem_rdata, drives acks and mem_*)
//   slave  : environment view (requesters plus memory)
//   Fetch   : if_req, if_addr -> if_ack, if_rdata, if_err
//   Data    : d_req, d_we, d_be, d_addr, d_wdata -> d_ack, d_rdata, d_err
//   Memory  : mem_valid, mem_we, mem_be, mem_addr, mem_wdata <- mem_ready, mem_rdata
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_err;

    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        mem_valid;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        input  if_req, if_addr,
        output if_ack, if_rdata, if_err,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_ack, d_rdata, d_err,
        output mem_valid, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        output if_req, if_addr,
        input  if_ack, if_rdata, if_err,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_ack, d_rdata, d_err,
        input  mem_valid, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch (I) and load/store (D).
//   Each access runs IDLE -> BUSY -> ACK -> IDLE; every output is registered.
//   D wins ties until STARVE_LIMIT consecutive D grants have passed over a
//   pending fetch, then I is forced through. A BUSY access with no mem_ready
//   for TIMEOUT cycles is aborted and acked with err=1 (TIMEOUT=0 disables).
// Ports
//   clk   : clock, all state updates on posedge
//   reset : asynchronous, active-high
//   bus   : mem_port_arbiter_if.master (fetch, data and memory handshakes)
//
// state | meaning
// IDLE  | no access in flight, arbitrate pending requests
// BUSY  | mem_valid held with latched request fields, waiting for mem_ready
// ACK   | one-cycle ack pulse to the owner, no arbitration
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.master  bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_ACK
    } state_t;

    state_t        state;
    logic          owner_d;
    logic [SW-1:0] starve_cnt;
    logic [7:0]    tmo_cnt;
    logic          grant_d;
    logic          tmo_hit;

    assign grant_d = bus.d_req && (!bus.if_req || (starve_cnt < SW'(STARVE_LIMIT)));
    // tmo_cnt is 0 in the first BUSY cycle, so the abort edge is at count TIMEOUT-1
    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            owner_d       <= 1'b0;
            starve_cnt    <= '0;
            tmo_cnt       <= '0;
            bus.if_ack    <= 1'b0;
            bus.if_rdata  <= '0;
            bus.if_err    <= 1'b0;
            bus.d_ack     <= 1'b0;
            bus.d_rdata   <= '0;
            bus.d_err     <= 1'b0;
            bus.mem_valid <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        state         <= S_BUSY;
                        tmo_cnt       <= '0;
                        bus.mem_valid <= 1'b1;
                        if (grant_d) begin
                            owner_d       <= 1'b1;
                            bus.mem_we    <= bus.d_we;
                            bus.mem_be    <= bus.d_we ? bus.d_be : 4'hF;
                            bus.mem_addr  <= bus.d_addr;
                            bus.mem_wdata <= bus.d_we ? bus.d_wdata : 32'd0;
                            if (!bus.if_req) begin
                                starve_cnt <= '0;
                            end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
                                starve_cnt <= starve_cnt + SW'(1);
                            end
                        end else begin
                            owner_d       <= 1'b0;
                            bus.mem_we    <= 1'b0;
                            bus.mem_be    <= 4'hF;
                            bus.mem_addr  <= bus.if_addr;
                            bus.mem_wdata <= 32'd0;
                            starve_cnt    <= '0;
                        end
                    end
                end

                S_BUSY: begin
                    // ready has priority over a timeout landing on the same edge
                    if (bus.mem_ready || tmo_hit) begin
                        state         <= S_ACK;
                        bus.mem_valid <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        bus.mem_be    <= '0;
                        bus.mem_addr  <= '0;
                        bus.mem_wdata <= '0;
                        if (owner_d) begin
                            bus.d_ack   <= 1'b1;
                            bus.d_rdata <= (bus.mem_ready && !bus.mem_we) ? bus.mem_rdata : 32'd0;
                            bus.d_err   <= !bus.mem_ready;
                        end else begin
                            bus.if_ack   <= 1'b1;
                            bus.if_rdata <= bus.mem_ready ? bus.mem_rdata : 32'd0;
                            bus.if_err   <= !bus.mem_ready;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end

                S_ACK: begin
                    state        <= S_IDLE;
                    bus.if_ack   <= 1'b0;
                    bus.if_rdata <= '0;
                    bus.if_err   <= 1'b0;
                    bus.d_ack    <= 1'b0;
                    bus.d_rdata  <= '0;
                    bus.d_err    <= 1'b0;
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Scoreboard bench: the stimulus process drives requesters and a memory
//   responder; the monitor predicts grants, memory fields and acks from the
//   arbitration rules and compares everything the DUT presents.
module tb_mem_port_arbiter;
    localparam int SL  = 4;
    localparam int TMO = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        bit          err;
        int          due;
    } exp_t;

    exp_t expq[$];
    bit   grant_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- monitor / reference model ----------------
    logic        p_ireq, p_dreq, p_dwe, p_rdy;
    logic [31:0] p_iaddr, p_daddr, p_dwdata, p_rdata;
    logic [3:0]  p_dbe;
    int          cyc = 0;
    int          starve_m = 0;
    int          busy_cnt = 0;
    int          last_end = -100;
    bit          prev_mv = 0;
    bit          cur_d;
    logic        cur_we;
    logic [3:0]  cur_be;
    logic [31:0] cur_addr, cur_wdata;

    initial begin : monitor
        exp_t e;
        bit   exp_d, act_d;
        forever begin
            @(posedge clk);
            p_ireq = bus.if_req;  p_iaddr = bus.if_addr;
            p_dreq = bus.d_req;   p_dwe = bus.d_we;  p_dbe = bus.d_be;
            p_daddr = bus.d_addr; p_dwdata = bus.d_wdata;
            p_rdy = bus.mem_ready; p_rdata = bus.mem_rdata;
            @(negedge clk);
            cyc++;
            if (reset) begin
                expq.delete();
                starve_m = 0;
                busy_cnt = 0;
                prev_mv  = 0;
                last_end = -100;
            end else begin
                // memory side: end of an access or start of a new grant
                if (prev_mv) begin
                    if (p_rdy || (TMO != 0 && busy_cnt == TMO)) begin
                        check("mem_valid_drop", 32'(bus.mem_valid), 32'd0);
                        e.is_d  = cur_d;
                        e.rdata = p_rdy ? (cur_we ? 32'd0 : p_rdata) : 32'd0;
                        e.err   = !p_rdy;
                        e.due   = cyc;
                        expq.push_back(e);
                        last_end = cyc;
                    end else begin
                        check("mem_valid_hold", 32'(bus.mem_valid), 32'd1);
                        check("mem_addr_hold", bus.mem_addr, cur_addr);
                        check("mem_we_hold", 32'(bus.mem_we), 32'(cur_we));
                        check("mem_be_hold", 32'(bus.mem_be), 32'(cur_be));
                        check("mem_wdata_hold", bus.mem_wdata, cur_wdata);
                    end
                end else if (bus.mem_valid) begin
                    exp_d = p_dreq && (!p_ireq || starve_m < SL);
                    act_d = (bus.mem_addr[31:20] == 12'h100);
                    check("arb_gap", 32'(cyc - last_end >= 2), 32'd1);
                    check("req_present", 32'(p_ireq | p_dreq), 32'd1);
                    check("grant_owner", 32'(act_d), 32'(exp_d));
                    cur_d = exp_d;
                    if (exp_d) begin
                        cur_we    = p_dwe;
                        cur_be    = p_dwe ? p_dbe : 4'hF;
                        cur_addr  = p_daddr;
                        cur_wdata = p_dwe ? p_dwdata : 32'd0;
                        starve_m  = p_ireq ? ((starve_m < SL) ? starve_m + 1 : SL) : 0;
                    end else begin
                        cur_we    = 1'b0;
                        cur_be    = 4'hF;
                        cur_addr  = p_iaddr;
                        cur_wdata = 32'd0;
                        starve_m  = 0;
                    end
                    check("grant_addr", bus.mem_addr, cur_addr);
                    check("grant_we", 32'(bus.mem_we), 32'(cur_we));
                    check("grant_be", 32'(bus.mem_be), 32'(cur_be));
                    check("grant_wdata", bus.mem_wdata, cur_wdata);
                    busy_cnt = 0;
                    grant_log.push_back(act_d);
                end
                if (bus.mem_valid) busy_cnt++;
                prev_mv = bus.mem_valid;

                // ack side
                check("ack_exclusive", 32'(bus.if_ack & bus.d_ack), 32'd0);
                if (!bus.if_ack) begin
                    check("if_rdata_idle", bus.if_rdata, 32'd0);
                    check("if_err_idle", 32'(bus.if_err), 32'd0);
                end
                if (!bus.d_ack) begin
                    check("d_rdata_idle", bus.d_rdata, 32'd0);
                    check("d_err_idle", 32'(bus.d_err), 32'd0);
                end
                while (expq.size() > 0 && expq[0].due < cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL ack_missing: actual=no ack required=ack due cycle %0d", expq[0].due);
                    void'(expq.pop_front());
                end
                if (bus.if_ack || bus.d_ack) begin
                    n_checks++;
                    if (expq.size() == 0) begin
                        n_fail++;
                        $display("FAIL ack_unexpected: actual=ack required=no ack at cycle %0d", cyc);
                    end else begin
                        e = expq.pop_front();
                        check("ack_owner", 32'(bus.d_ack), 32'(e.is_d));
                        check("ack_cycle", 32'(cyc), 32'(e.due));
                        if (e.is_d) begin
                            check("d_rdata", bus.d_rdata, e.rdata);
                            check("d_err", 32'(bus.d_err), 32'(e.err));
                        end else begin
                            check("if_rdata", bus.if_rdata, e.rdata);
                            check("if_err", 32'(bus.if_err), 32'(e.err));
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int          keep_i = 0, raise_i = 0, keep_d = 0, raise_d = 0;
    int          rsp_mode = 1, rsp_delay = 1, rsp_target = 0, rcnt = 0;
    bit          fix_en = 0;
    logic [31:0] fix_data = '0;
    bit          got_i, got_d, g_ierr, g_derr, f_seen, f_we;
    logic [31:0] g_irdata, g_drdata, f_addr, f_wdata;
    logic [3:0]  f_be;
    int          mv_cycles;

    function automatic bit roll(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    task automatic new_i();
        bus.if_addr = 32'h0040_0000 | ($urandom & 32'h000F_FFFC);
    endtask

    task automatic new_d();
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_be    = 4'($urandom);
        bus.d_addr  = 32'h1000_0000 | ($urandom & 32'h000F_FFFF);
        bus.d_wdata = $urandom;
    endtask

    task automatic drive_reqs();
        if (bus.if_req) begin
            if (bus.if_ack) begin
                if (roll(keep_i)) new_i();
                else bus.if_req = 1'b0;
            end
        end else if (roll(raise_i)) begin
            bus.if_req = 1'b1;
            new_i();
        end
        if (bus.d_req) begin
            if (bus.d_ack) begin
                if (roll(keep_d)) new_d();
                else bus.d_req = 1'b0;
            end
        end else if (roll(raise_d)) begin
            bus.d_req = 1'b1;
            new_d();
        end
    endtask

    // mode 0: random latency 1..10 (9,10 time out), 1: fixed rsp_delay,
    // 2: never ready, 3: ready on the last cycle before timeout
    task automatic drive_mem();
        if (bus.mem_valid) begin
            rcnt++;
            if (rcnt == 1) begin
                case (rsp_mode)
                    0:       rsp_target = int'($urandom_range(1, 10));
                    1:       rsp_target = rsp_delay;
                    3:       rsp_target = TMO;
                    default: rsp_target = 0;
                endcase
            end
            bus.mem_ready = (rcnt == rsp_target);
            bus.mem_rdata = fix_en ? fix_data : $urandom;
        end else begin
            rcnt          = 0;
            bus.mem_ready = 1'b0;
            bus.mem_rdata = '0;
        end
    endtask

    task automatic clear_capture();
        got_i = 0; got_d = 0; g_ierr = 0; g_derr = 0; f_seen = 0; mv_cycles = 0;
        g_irdata = '0; g_drdata = '0; f_addr = '0; f_wdata = '0; f_be = '0; f_we = 0;
    endtask

    task automatic step();
        @(negedge clk);
        if (bus.mem_valid) begin
            mv_cycles++;
            if (!f_seen) begin
                f_seen = 1; f_addr = bus.mem_addr; f_we = bus.mem_we;
                f_be = bus.mem_be; f_wdata = bus.mem_wdata;
            end
        end
        if (bus.if_ack) begin got_i = 1; g_irdata = bus.if_rdata; g_ierr = bus.if_err; end
        if (bus.d_ack)  begin got_d = 1; g_drdata = bus.d_rdata;  g_derr = bus.d_err;  end
        drive_reqs();
        drive_mem();
    endtask

    task automatic run_until_idle(input int budget, input string name);
        int n = 0;
        while ((bus.if_req || bus.d_req) && n < budget) begin
            step();
            n++;
        end
        check({name, "_drained"}, 32'({bus.if_req, bus.d_req}), 32'd0);
        step();
        step();
    endtask

    initial begin : stim
        int n, g0;
        bus.if_req = 0; bus.if_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_ready = 0; bus.mem_rdata = '0;
        clear_capture();

        repeat (3) step();
        check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_if_ack", 32'(bus.if_ack), 32'd0);
        check("rst_d_ack", 32'(bus.d_ack), 32'd0);
        check("rst_if_rdata", bus.if_rdata, 32'd0);
        reset = 1'b0;
        step();

        // fetch only, ready one cycle after valid
        clear_capture();
        fix_en = 1; fix_data = 32'h8C08_0000; rsp_mode = 1; rsp_delay = 2;
        bus.if_req = 1; bus.if_addr = 32'h0040_0000;
        run_until_idle(20, "t1");
        check("t1_mem_addr", f_addr, 32'h0040_0000);
        check("t1_mem_we", 32'(f_we), 32'd0);
        check("t1_got_if_ack", 32'(got_i), 32'd1);
        check("t1_if_rdata", g_irdata, 32'h8C08_0000);
        check("t1_no_d_ack", 32'(got_d), 32'd0);
        check("t1_valid_cycles", 32'(mv_cycles), 32'd2);
        fix_en = 0;

        // tie: D first, then I
        clear_capture();
        rsp_delay = 1;
        g0 = grant_log.size();
        bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'h0; bus.d_addr = 32'h1000_4000; bus.d_wdata = 32'h1234_5678;
        bus.if_req = 1; bus.if_addr = 32'h0040_0004;
        run_until_idle(40, "t2");
        check("t2_grants", 32'(grant_log.size() - g0), 32'd2);
        if (grant_log.size() >= g0 + 2) begin
            check("t2_first_d", 32'(grant_log[g0]), 32'd1);
            check("t2_second_i", 32'(grant_log[g0 + 1]), 32'd0);
        end
        check("t2_load_be", 32'(f_be), 32'hF);
        check("t2_load_wdata", f_wdata, 32'd0);

        // starvation: both held continuously
        g0 = grant_log.size();
        keep_i = 100; keep_d = 100;
        bus.if_req = 1; new_i();
        bus.d_req = 1; new_d();
        n = 0;
        while (grant_log.size() < g0 + 10 && n < 300) begin
            step();
            n++;
        end
        keep_i = 0; keep_d = 0;
        run_until_idle(100, "t3");
        check("t3_grant_count", 32'(grant_log.size() >= g0 + 10), 32'd1);
        if (grant_log.size() >= g0 + 10) begin
            for (int k = 0; k < 10; k++)
                check($sformatf("t3_grant%0d", k), 32'(grant_log[g0 + k]), 32'((k % 5) != 4));
        end

        // store
        clear_capture();
        bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b0011;
        bus.d_addr = 32'h1000_4000; bus.d_wdata = 32'hDEAD_BEEF;
        run_until_idle(20, "t4");
        check("t4_mem_we", 32'(f_we), 32'd1);
        check("t4_mem_be", 32'(f_be), 32'h3);
        check("t4_mem_addr", f_addr, 32'h1000_4000);
        check("t4_mem_wdata", f_wdata, 32'hDEAD_BEEF);
        check("t4_got_d_ack", 32'(got_d), 32'd1);
        check("t4_d_rdata", g_drdata, 32'd0);
        check("t4_d_err", 32'(g_derr), 32'd0);

        // timeout, then ready on the limit cycle
        clear_capture();
        rsp_mode = 2;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h1000_0100;
        run_until_idle(40, "t5a");
        check("t5a_got_d_ack", 32'(got_d), 32'd1);
        check("t5a_d_err", 32'(g_derr), 32'd1);
        check("t5a_d_rdata", g_drdata, 32'd0);
        check("t5a_valid_cycles", 32'(mv_cycles), 32'(TMO));
        clear_capture();
        rsp_mode = 3;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h1000_0200;
        run_until_idle(40, "t5b");
        check("t5b_got_d_ack", 32'(got_d), 32'd1);
        check("t5b_d_err", 32'(g_derr), 32'd0);
        check("t5b_valid_cycles", 32'(mv_cycles), 32'(TMO));

        // reset while BUSY
        clear_capture();
        rsp_mode = 2;
        bus.if_req = 1; bus.if_addr = 32'h0040_0010;
        n = 0;
        while (!bus.mem_valid && n < 10) begin
            step();
            n++;
        end
        step();
        step();
        #2 reset = 1'b1;
        #1;
        check("t6_mem_valid", 32'(bus.mem_valid), 32'd0);
        check("t6_mem_addr", bus.mem_addr, 32'd0);
        check("t6_mem_be", 32'(bus.mem_be), 32'd0);
        check("t6_if_ack", 32'(bus.if_ack), 32'd0);
        check("t6_d_ack", 32'(bus.d_ack), 32'd0);
        clear_capture();
        rsp_mode = 1; rsp_delay = 1;
        step();
        step();
        check("t6_no_ack_in_reset", 32'(got_i | got_d), 32'd0);
        #2 reset = 1'b0;
        run_until_idle(30, "t6");
        check("t6_reissue_ack", 32'(got_i), 32'd1);
        check("t6_reissue_err", 32'(g_ierr), 32'd0);
        check("t6_reissue_addr", f_addr, 32'h0040_0010);

        // random traffic
        rsp_mode = 0;
        keep_i = 50; raise_i = 30; keep_d = 50; raise_d = 30;
        repeat (800) step();
        keep_i = 0; raise_i = 0; keep_d = 0; raise_d = 0;
        run_until_idle(200, "rand");
        repeat (3) step();
        check("scoreboard_empty", 32'(expq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
